pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 15 +
 rtl/pipe_hazard_ctrl_hazard_cmp.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encodings,
// register-index width and the default memory-wait timeout.
package pipe_hazard_ctrl_pkg;

  localparam int REG_IDX_W           = 5;
  localparam int WAIT_CNT_W          = 8;
  localparam int MEM_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Load-use comparator: flags an ID instruction that reads the destination of a
// load currently in EX. Writes to x0 never create a dependency.
module hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  input  logic                 rs1_used,
  input  logic                 rs2_used,
  input  logic [REG_IDX_W-1:0] rd_idx,
  input  logic                 rd_wben,
  input  logic                 rd_is_load,
  output logic                 load_use
);

  assign load_use = rd_is_load & rd_wben & (rd_idx != '0) &
                    ((rs1_used & (rs1_idx == rd_idx)) |
                     (rs2_used & (rs2_idx == rd_idx)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, redirect flushes and data-memory
// wait/timeout handling. Optional perf counters under `HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1_idx,
  input  logic [REG_IDX_W-1:0] id_rs2_idx,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [REG_IDX_W-1:0] ex_rd_idx,
  input  logic                 ex_wben,
  input  logic                 ex_is_load,
  input  logic                 ex_redirect,
  input  logic                 lsu_req,
  input  logic                 lsu_ready,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 idex_en,
  output logic                 exmem_en,
  output logic                 flush_ifid,
  output logic                 flush_idex,
  output logic                 mem_timeout,
  output logic [1:0]           state_o
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt
`endif
);

  localparam logic [WAIT_CNT_W:0] TIMEOUT_V = (WAIT_CNT_W+1)'(MEM_TIMEOUT);

  hz_state_e               state, state_next;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic [WAIT_CNT_W:0]     wait_inc;
  logic                    load_use;
  logic                    mem_stall;
  logic                    timeout_hit;
  logic                    redirect_taken;

  hazard_cmp u_cmp (
    .rs1_idx    (id_rs1_idx),
    .rs2_idx    (id_rs2_idx),
    .rs1_used   (id_rs1_used),
    .rs2_used   (id_rs2_used),
    .rd_idx     (ex_rd_idx),
    .rd_wben    (ex_wben),
    .rd_is_load (ex_is_load),
    .load_use   (load_use)
  );

  assign mem_stall = lsu_req & ~lsu_ready;
  // ERR is entered after exactly MEM_TIMEOUT consecutive MEM_WAIT cycles.
  assign wait_inc    = {1'b0, wait_cnt} + 1'b1;
  assign timeout_hit = (wait_inc == TIMEOUT_V);
  assign state_o     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state == MEM_WAIT && state_next == MEM_WAIT) ? wait_inc[WAIT_CNT_W-1:0] : '0;
      if (state_next == ERR)
        mem_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_next     = state;
    pc_en          = 1'b1;
    ifid_en        = 1'b1;
    idex_en        = 1'b1;
    exmem_en       = 1'b1;
    flush_ifid     = 1'b0;
    flush_idex     = 1'b0;
    redirect_taken = 1'b0;
    case (state)
      RUN: begin
        // A pending memory access freezes everything and masks EX/ID hazards.
        if (mem_stall) begin
          {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
          state_next = MEM_WAIT;
        end else if (ex_redirect) begin
          flush_ifid     = 1'b1;
          flush_idex     = 1'b1;
          redirect_taken = 1'b1;
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          flush_idex = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (lsu_ready) begin
          state_next = RUN;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
          if (timeout_hit)
            state_next = ERR;
        end
      end
      ERR: begin
        {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end
      default: begin
        {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        state_next = RUN;
      end
    endcase
    // During reset every stage register loads a bubble.
    if (rst) begin
      {pc_en, ifid_en, idex_en, exmem_en} = 4'b1111;
      flush_ifid     = 1'b1;
      flush_idex     = 1'b1;
      redirect_taken = 1'b0;
      state_next     = RUN;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en)
        stall_cnt <= stall_cnt + 32'd1;
      if (redirect_taken)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4); perf counters are
// checked when HAZ_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1_idx, id_rs2_idx, ex_rd_idx;
  logic       id_rs1_used, id_rs2_used, ex_wben, ex_is_load, ex_redirect;
  logic       lsu_req, lsu_ready;
  logic       pc_en, ifid_en, idex_en, exmem_en, flush_ifid, flush_idex, mem_timeout;
  logic [1:0] state_o;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];
  string      name_q[$];

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd_idx(ex_rd_idx), .ex_wben(ex_wben), .ex_is_load(ex_is_load),
    .ex_redirect(ex_redirect), .lsu_req(lsu_req), .lsu_ready(lsu_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .mem_timeout(mem_timeout), .state_o(state_o)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected vector: {pc_en, ifid_en, idex_en, exmem_en, flush_ifid, flush_idex, mem_timeout, state}
  function automatic logic [8:0] ev(input logic [3:0] en, input logic [1:0] fl,
                                    input logic mt, input logic [1:0] st);
    return {en, fl, mt, st};
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic [4:0] rd, input logic wb, input logic ld,
                               input logic redir, input logic req, input logic rdy,
                               input logic [8:0] exp, input string nm);
    rst = r;
    id_rs1_idx = rs1; id_rs1_used = u1;
    id_rs2_idx = rs2; id_rs2_used = u2;
    ex_rd_idx = rd; ex_wben = wb; ex_is_load = ld;
    ex_redirect = redir; lsu_req = req; lsu_ready = rdy;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are combinational, so every cycle with a queued expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [8:0] e;
      string      n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checkOutput(n, 32'({pc_en, ifid_en, idex_en, exmem_en, flush_ifid, flush_idex,
                          mem_timeout, state_o}), 32'(e));
    end
  end

  initial begin
    rst = 1'b1;
    {id_rs1_idx, id_rs2_idx, ex_rd_idx} = '0;
    {id_rs1_used, id_rs2_used, ex_wben, ex_is_load, ex_redirect, lsu_req, lsu_ready} = '0;
    @(posedge clk);
    #1;

    //            rst rs1 u1 rs2 u2 rd wb ld rdr req rdy  expected
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev(4'hF, 2'b11, 0, 0), "reset");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev(4'hF, 2'b00, 0, 0), "run_idle");
    applyStimulus(0, 3, 1, 5, 1, 5, 1, 1, 0, 0, 0, ev(4'b0011, 2'b01, 0, 0), "loaduse_rs2");
    applyStimulus(0, 3, 1, 5, 1, 0, 0, 0, 0, 0, 0, ev(4'hF, 2'b00, 0, 0), "after_bubble");
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, ev(4'hF, 2'b00, 0, 0), "x0_load");
    applyStimulus(0, 7, 0, 2, 1, 7, 1, 1, 0, 0, 0, ev(4'hF, 2'b00, 0, 0), "unused_rs");
    applyStimulus(0, 9, 1, 0, 0, 9, 0, 1, 0, 0, 0, ev(4'hF, 2'b00, 0, 0), "no_wben");
    applyStimulus(0, 9, 1, 0, 0, 9, 1, 1, 0, 0, 0, ev(4'b0011, 2'b01, 0, 0), "loaduse_rs1");
    applyStimulus(0, 1, 1, 5, 1, 5, 1, 1, 1, 0, 0, ev(4'hF, 2'b11, 0, 0), "redir_lu");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, ev(4'hF, 2'b00, 0, 0), "lsu_zero_wait");
    // three cycles of lsu_ready low, then ready
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, ev(4'h0, 2'b00, 0, 0), "mem_stall_run");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, ev(4'h0, 2'b00, 0, 1), "mem_wait1");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, ev(4'h0, 2'b00, 0, 1), "mem_wait2");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, ev(4'hF, 2'b00, 0, 1), "mem_ready");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev(4'hF, 2'b00, 0, 0), "mem_after");
    // timeout: run stall cycle, four wait cycles, then ERR
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ev(4'h0, 2'b00, 0, 0), "to_run");
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ev(4'h0, 2'b00, 0, 1), "to_wait");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ev(4'h0, 2'b11, 1, 2), "err");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, ev(4'h0, 2'b11, 1, 2), "err_rdy_ignored");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev(4'hF, 2'b11, 1, 2), "rst_in_err");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev(4'hF, 2'b00, 0, 0), "post_rst");
    // ready arrives in the same cycle the timeout would fire
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ev(4'h0, 2'b00, 0, 0), "race_run");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ev(4'h0, 2'b00, 0, 1), "race_wait");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, ev(4'hF, 2'b00, 0, 1), "race_ready");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev(4'hF, 2'b00, 0, 0), "race_after");
    // perf sequence: two load-use stalls and one redirect after a fresh reset
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev(4'hF, 2'b11, 0, 0), "perf_rst");
    applyStimulus(0, 4, 1, 0, 0, 4, 1, 1, 0, 0, 0, ev(4'b0011, 2'b01, 0, 0), "perf_lu1");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev(4'hF, 2'b00, 0, 0), "perf_idle1");
    applyStimulus(0, 0, 0, 6, 1, 6, 1, 1, 0, 0, 0, ev(4'b0011, 2'b01, 0, 0), "perf_lu2");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, ev(4'hF, 2'b11, 0, 0), "perf_redir");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ev(4'hF, 2'b00, 0, 0), "perf_idle2");
`ifdef HAZ_PERF_CNT_EN
    checkOutput("stall_cnt", stall_cnt, 32'd2);
    checkOutput("flush_cnt", flush_cnt, 32'd1);
`endif

    @(negedge clk);
    #1;
    for (int i = 0; i < 5 && exp_q.size() > 0; i++)
      @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
